mem_responder: RTL and testbench

- Memory-side endpoint of the cache/memory bus: receives requests from the bus arbiter and returns block read data.
- Accepts single-beat write transfers of dma_data_width_p words.
- Accepts single-cycle read requests. After a fixed latency it returns a burst of block_width_p/dma_data_width_p beats.
- Serves as the system main-memory model and as the functional stand-in for a DRAM controller.

---
 rtl/mem_responder.sv | 157 +++++++++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Main-memory endpoint of the cache/memory bus: absorbs single-beat writes and
// answers block reads with a fixed-latency, gap-free burst of response beats.
module mem_responder #(
    parameter int block_width_p    = 8,
    parameter int dma_data_width_p = 2,
    parameter int mem_words_p      = 1024,
    parameter int read_latency_p   = 3
) (
    input  logic                          clk_i,
    input  logic                          nreset_i,
    input  logic                          mem_valid_i,
    output logic                          mem_ready_o,
    input  logic                          mem_we_i,
    input  logic [31:0]                   mem_addr_i,
    input  logic [dma_data_width_p*32-1:0] mem_wdata_i,
    output logic                          mem_valid_o,
    output logic [dma_data_width_p*32-1:0] mem_data_o
);

    localparam int BEATS_LP  = block_width_p / dma_data_width_p;
    localparam int BEAT_W_LP = (BEATS_LP > 1) ? $clog2(BEATS_LP) : 1;
    localparam int IDX_W_LP  = $clog2(mem_words_p);
    localparam int LAT_W_LP  = (read_latency_p > 1) ? $clog2(read_latency_p) : 1;
    localparam int DATA_W_LP = dma_data_width_p * 32;
    localparam int DW_LOG_LP = $clog2(dma_data_width_p);

    localparam logic [IDX_W_LP-1:0]  WR_MASK_LP   = ~IDX_W_LP'(dma_data_width_p - 1);
    localparam logic [IDX_W_LP-1:0]  RD_MASK_LP   = ~IDX_W_LP'(block_width_p - 1);
    localparam logic [BEAT_W_LP-1:0] LAST_BEAT_LP = BEAT_W_LP'(BEATS_LP - 1);

    typedef enum logic [1:0] {
        IDLE_S,
        READ_WAIT_S,
        READ_BURST_S
    } state_e;

    state_e                 state_q, state_d;
    logic [BEAT_W_LP-1:0]   beat_q, beat_d;
    logic [LAT_W_LP-1:0]    lat_q, lat_d;
    logic [IDX_W_LP-1:0]    base_q, base_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [DATA_W_LP-1:0]   data_q, data_d;

    logic [31:0]            mem_q [mem_words_p];

    logic [IDX_W_LP-1:0]    addr_idx;
    logic [IDX_W_LP-1:0]    wr_idx;
    logic [IDX_W_LP-1:0]    beat_addr;
    logic [DATA_W_LP-1:0]   beat_data;
    logic                   accept;
    logic                   unused_addr;

    assign addr_idx    = mem_addr_i[2 +: IDX_W_LP];
    assign wr_idx      = addr_idx & WR_MASK_LP;
    assign accept      = mem_valid_i & ready_q;
    assign unused_addr = ^{mem_addr_i[31:IDX_W_LP+2], mem_addr_i[1:0]};

    assign mem_ready_o = ready_q;
    assign mem_valid_o = valid_q;
    assign mem_data_o  = data_q;

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (nreset_i && accept && mem_we_i) begin
            for (int k = 0; k < dma_data_width_p; k++) begin
                mem_q[wr_idx + IDX_W_LP'(k)] <= mem_wdata_i[32*k +: 32];
            end
        end
    end

    assign beat_addr = base_q + (IDX_W_LP'(beat_q) << DW_LOG_LP);

    always_comb begin
        beat_data = '0;
        for (int k = 0; k < dma_data_width_p; k++) begin
            beat_data[32*k +: 32] = mem_q[beat_addr + IDX_W_LP'(k)];
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= IDLE_S;
            beat_q  <= '0;
            lat_q   <= '0;
            base_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            base_q  <= base_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Ready stays low through the edge that registers the last beat, so it
    // only rises in the cycle after that beat is on the bus.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        base_d  = base_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        data_d  = '0;

        case (state_q)
            IDLE_S: begin
                ready_d = 1'b1;
                if (accept && !mem_we_i) begin
                    base_d  = addr_idx & RD_MASK_LP;
                    beat_d  = '0;
                    ready_d = 1'b0;
                    lat_d   = LAT_W_LP'(read_latency_p - 1);
                    if (read_latency_p == 1) begin
                        state_d = READ_BURST_S;
                    end else begin
                        state_d = READ_WAIT_S;
                    end
                end
            end

            READ_WAIT_S: begin
                ready_d = 1'b0;
                if (lat_q <= LAT_W_LP'(1)) begin
                    lat_d   = '0;
                    state_d = READ_BURST_S;
                end else begin
                    lat_d = lat_q - LAT_W_LP'(1);
                end
            end

            READ_BURST_S: begin
                ready_d = 1'b0;
                valid_d = 1'b1;
                data_d  = beat_data;
                if (beat_q == LAST_BEAT_LP) begin
                    beat_d  = '0;
                    state_d = IDLE_S;
                end else begin
                    beat_d = beat_q + BEAT_W_LP'(1);
                end
            end

            default: begin
                state_d = IDLE_S;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a word-array/queue model predicts every
// output each cycle, and directed sequences pin the model with literal values.
module tb_mem_responder;

    localparam int BLOCK_W = 8;
    localparam int DMA_W   = 2;
    localparam int DEPTH   = 1024;
    localparam int LAT     = 3;
    localparam int BEATS   = BLOCK_W / DMA_W;

    logic              clk_i;
    logic              nreset_i;
    logic              mem_valid_i;
    logic              mem_ready_o;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [DMA_W*32-1:0] mem_wdata_i;
    logic              mem_valid_o;
    logic [DMA_W*32-1:0] mem_data_o;

    mem_responder #(
        .block_width_p   (BLOCK_W),
        .dma_data_width_p(DMA_W),
        .mem_words_p     (DEPTH),
        .read_latency_p  (LAT)
    ) dut (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .mem_valid_i(mem_valid_i),
        .mem_ready_o(mem_ready_o),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_valid_o(mem_valid_o),
        .mem_data_o (mem_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cycle;
        logic [63:0] data;
    } beat_t;

    logic [31:0] modelMem [DEPTH];
    beat_t       expQ [$];
    int          cyc = 0;
    int          busyUntil = 0;
    int          checkCount = 0;
    int          passCount = 0;
    int          failCount = 0;
    bit          checking = 0;
    logic [63:0] gotBeat [BEATS];
    logic [63:0] litBeat [BEATS];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            if (failCount <= 40)
                $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [31:0] addr,
                                 input logic [63:0] wdata);
        @(negedge clk_i);
        mem_valid_i = v;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
    endtask

    // Model: ready is low for LAT+BEATS cycles after a read accept; beats are
    // scheduled by edge number and their data fixed at accept time.
    always @(posedge clk_i) begin
        cyc = cyc + 1;
        if (!nreset_i) begin
            expQ.delete();
            busyUntil = 0;
        end else if (mem_valid_i && (cyc - 1 >= busyUntil)) begin
            int idx;
            idx = int'(mem_addr_i >> 2) % DEPTH;
            if (mem_we_i) begin
                idx = idx - (idx % DMA_W);
                for (int k = 0; k < DMA_W; k++)
                    modelMem[idx + k] = mem_wdata_i[32*k +: 32];
            end else begin
                idx = idx - (idx % BLOCK_W);
                for (int b = 0; b < BEATS; b++) begin
                    beat_t e;
                    e.cycle = cyc + LAT + b;
                    e.data  = {modelMem[idx + b*DMA_W + 1], modelMem[idx + b*DMA_W]};
                    expQ.push_back(e);
                end
                busyUntil = cyc + LAT + BEATS;
            end
        end
    end

    always @(negedge clk_i) begin
        if (checking) begin
            logic        expReady;
            logic        expValid;
            logic [63:0] expData;
            expReady = 1'b1;
            expValid = 1'b0;
            expData  = '0;
            if (nreset_i) begin
                expReady = (cyc >= busyUntil);
                if (expQ.size() > 0 && expQ[0].cycle == cyc) begin
                    expValid = 1'b1;
                    expData  = expQ[0].data;
                end
            end
            while (expQ.size() > 0 && expQ[0].cycle <= cyc) void'(expQ.pop_front());
            checkOutput("ready", 64'(mem_ready_o), 64'(expReady));
            checkOutput("valid", 64'(mem_valid_o), 64'(expValid));
            checkOutput("data", mem_data_o, expData);
        end
    end

    // Issues one read and checks latency/occupancy literally, holding a
    // write request on the bus throughout the busy window.
    task automatic directedRead(input logic [31:0] addr);
        applyStimulus(1'b1, 1'b0, addr, 64'h0);
        for (int i = 0; i <= LAT + BEATS; i++) begin
            if (i < LAT + BEATS)
                applyStimulus(1'b1, 1'b1, 32'h40, {64{1'b1}});
            else
                applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
            if (i == 0) checkOutput("dir_ready_low", 64'(mem_ready_o), 64'd0);
            checkOutput("dir_valid_timing", 64'(mem_valid_o),
                        64'((i >= LAT) && (i < LAT + BEATS)));
            if (i >= LAT && i < LAT + BEATS) gotBeat[i - LAT] = mem_data_o;
            if (i == LAT + BEATS) checkOutput("dir_ready_after", 64'(mem_ready_o), 64'd1);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk_i);
        #1 nreset_i = 1'b0;
        #1;
        checkOutput("rst_async_valid", 64'(mem_valid_o), 64'd0);
        checkOutput("rst_async_data", mem_data_o, 64'd0);
        checkOutput("rst_async_ready", 64'(mem_ready_o), 64'd1);
        @(negedge clk_i);
        #1 nreset_i = 1'b1;
    endtask

    initial begin
        int validSeen;
        nreset_i    = 1'b0;
        mem_valid_i = 1'b0;
        mem_we_i    = 1'b0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        litBeat[0] = 64'h00000001_00000000;
        litBeat[1] = 64'h00000003_00000002;
        litBeat[2] = 64'h00000005_00000004;
        litBeat[3] = 64'h00000007_00000006;

        #1;
        checking = 1;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_ready", 64'(mem_ready_o), 64'd1);
        checkOutput("reset_valid", 64'(mem_valid_o), 64'd0);
        checkOutput("reset_data", mem_data_o, 64'd0);
        #1 nreset_i = 1'b1;
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);

        for (int i = 0; i < DEPTH / DMA_W; i++)
            applyStimulus(1'b1, 1'b1, 32'(i * 8), {$urandom, $urandom});

        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b1, 32'h40 + 32'(k * 8), {32'(k * 2 + 1), 32'(k * 2)});
        directedRead(32'h44);
        for (int b = 0; b < BEATS; b++) checkOutput("lit_beat", gotBeat[b], litBeat[b]);

        directedRead(32'h40);
        checkOutput("ignored_write", gotBeat[0], litBeat[0]);

        applyStimulus(1'b1, 1'b1, 32'h40 + 32'(DEPTH * 4), 64'hA5A5A5A5_5A5A5A5A);
        directedRead(32'h40);
        checkOutput("alias_beat0", gotBeat[0], 64'hA5A5A5A5_5A5A5A5A);
        checkOutput("alias_beat1", gotBeat[1], 64'h00000003_00000002);

        applyStimulus(1'b1, 1'b0, 32'h40, 64'h0);
        for (int i = 0; i <= LAT + 1; i++) applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
        checkOutput("second_beat_valid", 64'(mem_valid_o), 64'd1);
        #1 nreset_i = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(mem_valid_o), 64'd0);
        checkOutput("mid_rst_data", mem_data_o, 64'd0);
        checkOutput("mid_rst_ready", 64'(mem_ready_o), 64'd1);
        @(negedge clk_i);
        #1 nreset_i = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
            if (mem_valid_o) validSeen++;
        end
        checkOutput("no_beats_after_rst", 64'(validSeen), 64'd0);
        checkOutput("ready_after_rst", 64'(mem_ready_o), 64'd1);
        directedRead(32'h40);
        checkOutput("post_rst_read", gotBeat[0], 64'hA5A5A5A5_5A5A5A5A);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                pulseReset();
            end else begin
                applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                              $urandom, {$urandom, $urandom});
            end
        end
        repeat (LAT + BEATS + 2) applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);

        checking = 0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
